// File: rtl/blinky_pkg.sv
// rtl/blinky_pkg.sv - mode encoding and width constants shared by blinky_array and its channels
package blinky_pkg;

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_ON      = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_BREATHE = 2'd3
   } mode_t;

   localparam int CH_IDX_BITS       = 4;
   localparam int DEF_PRESCALE_BITS = 20;
   localparam int DEF_PERIOD_BITS   = 8;
   localparam int DEF_PWM_BITS      = 8;

endpackage

// File: rtl/blinky_channel.sv
// rtl/blinky_channel.sv - one indicator channel: mode, period divider, blink state, breathe level
// BLINKY_ARRAY_BREATHE_EN adds the breathe level/direction registers and the pwmCount input.
module blinky_channel
   import blinky_pkg::*;
#(
   parameter int PERIOD_BITS = DEF_PERIOD_BITS,
`ifdef BLINKY_ARRAY_BREATHE_EN
   parameter int PWM_BITS = DEF_PWM_BITS,
`endif
   parameter logic [PERIOD_BITS-1:0] RESET_PERIOD = 15
) (
   input  logic                   clock,
   input  logic                   resetN,
   input  logic                   tick,
`ifdef BLINKY_ARRAY_BREATHE_EN
   input  logic [PWM_BITS-1:0]    pwmCount,
`endif
   input  logic                   load,
   input  logic [1:0]             loadMode,
   input  logic [PERIOD_BITS-1:0] loadPeriod,
   output logic                   blink
);

   mode_t                  mode;
   logic [PERIOD_BITS-1:0] period;
   logic [PERIOD_BITS-1:0] phase;
   logic                   state;
   logic                   step;
   logic                   breathe_out;
   logic                   blink_next;

   assign step = tick && (phase == period);

   // A load wins over a coincident tick, so a fresh period always starts from phase 0.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         mode   <= MODE_BLINK;
         period <= RESET_PERIOD;
         phase  <= '0;
         state  <= 1'b0;
      end else if (load) begin
         mode   <= mode_t'(loadMode);
         period <= loadPeriod;
         phase  <= '0;
         state  <= 1'b0;
      end else if (tick) begin
         phase <= step ? '0 : phase + 1'b1;
         if (step) state <= ~state;
      end
   end

`ifdef BLINKY_ARRAY_BREATHE_EN
   logic [PWM_BITS-1:0] level;
   logic [PWM_BITS-1:0] level_next;
   logic                down;

   assign level_next = down ? level - 1'b1 : level + 1'b1;

   // Direction flips on arriving at an end, so the turnaround costs no extra step.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         level <= '0;
         down  <= 1'b0;
      end else if (load) begin
         level <= '0;
         down  <= 1'b0;
      end else if (step && (mode == MODE_BREATHE)) begin
         level <= level_next;
         down  <= down ? (level_next != '0) : (level_next == '1);
      end
   end

   assign breathe_out = (pwmCount < level);
`else
   assign breathe_out = 1'b0;
`endif

   always_comb begin
      blink_next = 1'b0;
      case (mode)
         MODE_OFF:     blink_next = 1'b0;
         MODE_ON:      blink_next = 1'b1;
         MODE_BLINK:   blink_next = state;
         MODE_BREATHE: blink_next = breathe_out;
         default:      blink_next = 1'b0;
      endcase
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) blink <= 1'b0;
      else         blink <= blink_next;
   end

endmodule

// File: rtl/blinky_array.sv
// rtl/blinky_array.sv - multi-channel indicator driver: prescaler, PWM counter, write decode, channels
// BLINKY_ARRAY_BREATHE_EN enables BREATHE mode; without it mode 3 writes are rejected.
module blinky_array
   import blinky_pkg::*;
#(
   parameter int CHANNELS      = 4,
   parameter int PRESCALE_BITS = DEF_PRESCALE_BITS,
   parameter int PERIOD_BITS   = DEF_PERIOD_BITS,
   parameter int PWM_BITS      = DEF_PWM_BITS,
   parameter logic [PERIOD_BITS-1:0] RESET_PERIOD = 15
) (
   input  logic                   clock,
   input  logic                   resetN,
   input  logic                   cfgWrite,
   input  logic [CH_IDX_BITS-1:0] cfgChannel,
   input  logic [1:0]             cfgMode,
   input  logic [PERIOD_BITS-1:0] cfgPeriod,
   output logic                   cfgError,
   output logic [CHANNELS-1:0]    blink,
   output logic                   tick
);

   localparam logic [CH_IDX_BITS:0] CH_LIMIT = CHANNELS[CH_IDX_BITS:0];

   logic [PRESCALE_BITS-1:0] prescale;
   logic                     channel_ok;
   logic                     mode_ok;
   logic                     accept;
   logic                     reject_q;
   logic [CHANNELS-1:0]      load_vec;

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) prescale <= '0;
      else         prescale <= prescale + 1'b1;
   end

   assign tick = &prescale;

`ifdef BLINKY_ARRAY_BREATHE_EN
   logic [PWM_BITS-1:0] pwm_count;

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) pwm_count <= '0;
      else         pwm_count <= pwm_count + 1'b1;
   end

   assign mode_ok = 1'b1;
`else
   assign mode_ok = (cfgMode != MODE_BREATHE);
`endif

   assign channel_ok = ({1'b0, cfgChannel} < CH_LIMIT);
   assign accept     = cfgWrite && channel_ok && mode_ok;

   // Error is staged twice so it lines up with the output latency of an accepted write.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         reject_q <= 1'b0;
         cfgError <= 1'b0;
      end else begin
         reject_q <= cfgWrite && !accept;
         cfgError <= reject_q;
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      assign load_vec[i] = accept && (cfgChannel == CH_IDX_BITS'(i));

      blinky_channel #(
         .PERIOD_BITS  (PERIOD_BITS),
`ifdef BLINKY_ARRAY_BREATHE_EN
         .PWM_BITS     (PWM_BITS),
`endif
         .RESET_PERIOD (RESET_PERIOD)
      ) u_channel (
         .clock      (clock),
         .resetN     (resetN),
         .tick       (tick),
`ifdef BLINKY_ARRAY_BREATHE_EN
         .pwmCount   (pwm_count),
`endif
         .load       (load_vec[i]),
         .loadMode   (cfgMode),
         .loadPeriod (cfgPeriod),
         .blink      (blink[i])
      );
   end

endmodule

// File: doc/blinky_array.md
# blinky_array

Multi-channel successor to the single-counter blinker: drives `CHANNELS` independent indicator outputs (board LEDs/GPIOs), each with a runtime-selectable mode (off, on, blink at programmable period, PWM breathe). Sits directly under a board top module, clocked from any on-board derived clock. Configuration arrives over a one-cycle write strobe from a host block or tie-offs.

## Interface
- `CHANNELS`, 4: number of output channels (1..16)
- `PRESCALE_BITS`, 20: prescaler width; one tick every 2^PRESCALE_BITS clocks
- `PERIOD_BITS`, 8: width of per-channel period register
- `PWM_BITS`, 8: breathe PWM resolution
- `RESET_PERIOD`, 8'd15: period loaded into every channel at reset
- `clock`  in  1  sole clock
- `resetN`  in  1  asynchronous, active-low reset
- `cfgWrite`  in  1  one-cycle write strobe
- `cfgChannel`  in  4  target channel index
- `cfgMode`  in  2  0=OFF, 1=ON, 2=BLINK, 3=BREATHE
- `cfgPeriod`  in  PERIOD_BITS  ticks per blink half-cycle / per breathe step, minus one
- `cfgError`  out  1  one-cycle pulse: rejected write
- `blink`  out  CHANNELS  registered channel outputs
- `tick`  out  1  prescaler tick, one-cycle pulse

## Operation
- Reset (async assert, sync-style deassert at board level): prescaler=0, `tick`=0, `cfgError`=0, `blink`=0; every channel mode=BLINK, period=`RESET_PERIOD`, phase=0, state=0, level=0, direction=up.
- Prescaler: free-running PRESCALE_BITS counter; `tick` high for the cycle the counter equals all-ones.
- Per channel, on `tick`: if phase==period then phase<=0 and a step event fires; else phase<=phase+1. Period 0 = step every tick.
- OFF: output 0. ON: output 1. Phase still advances, ignored.
- BLINK: step event toggles state; output = state.
- BREATHE: free-running PWM_BITS counter (shared, every clock); step event moves level by 1 in current direction; at level all-ones while up, direction flips to down (level stays); at 0 while down, flips to up. Output = (pwmCount < level); level 0 gives constant 0.
- Write: when `cfgWrite`=1 and `cfgChannel` < CHANNELS, channel loads mode/period and clears phase, state, level, direction=up. Same-cycle tick for that channel is discarded; other channels step normally.
- Rejected write: `cfgChannel` >= CHANNELS, or mode 3 with breathe compiled out. No state change; `cfgError` pulses next cycle.
- Back-to-back writes accepted every cycle; no ready/backpressure.

## Timing
- `cfgWrite` sampled at edge k; channel registers updated at k; `blink[i]` reflects new mode at edge k+1 (2-edge latency, ON/OFF immediate after that).
- BLINK half-period = (period+1)·2^PRESCALE_BITS clocks.
- BREATHE full cycle = 2·(2^PWM_BITS−1)·(period+1) ticks.
- `cfgError` asserted edge k+1, cleared edge k+2 unless another rejected write.
- Reset mid-operation: all outputs 0 within the assertion, no clock required.

## Configuration
- `BLINKY_ARRAY_BREATHE_EN` defined: BREATHE mode, PWM counter, level/direction registers present.
- Undefined: mode 3 writes rejected with `cfgError`; no PWM counter or level registers synthesised; channel keeps its previous configuration.

## Structure
- `blinky_pkg`: mode enum (OFF/ON/BLINK/BREATHE), channel-index width constant, default widths.
- Sub-module `blinky_channel`: one channel's mode/period/phase/state/level logic, given `tick`, `pwmCount`, load strobe; instantiated CHANNELS times by generate. Prescaler, PWM counter, write decode and error pulse in top.

## Test plan
- Use PRESCALE_BITS=2, PERIOD_BITS=4, PWM_BITS=3 for bench.
- Reset release, RESET_PERIOD=1 -> all `blink` 0 at reset; each channel toggles every 8 clocks, all in phase.
- Write ch2 ON at edge k -> `blink[2]`=1 from edge k+1; ch0,1,3 keep toggling undisturbed.
- Write ch1 BLINK period 3 coincident with `tick` -> phase cleared, first toggle exactly 16 clocks later, then every 16.
- Write `cfgChannel`=5 with CHANNELS=4 -> `cfgError` one-cycle pulse at k+1, no output change.
- BREATHE period 0 -> level ramps 0..7..0 in 14 ticks; duty of `blink[i]` over 8-clock windows equals level/8; with macro undefined same write -> `cfgError`, channel unchanged.
- Assert `resetN` mid-breathe without clock -> `blink`=0 immediately; modes back to BLINK after release.
